// File: rtl/fpack_round.sv
// fpack_round: IEEE-754 single-precision result packer for the FPU tail.
// Normalizes, denormalizes, rounds and encodes with fflags over a 4-cycle FSM.
module fpack_round #(
  parameter int SIG_W = 48,
  parameter int EXP_W = 10
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [SIG_W-1:0] sig_i,
  input  logic [5:0]       class_i,
  input  logic [2:0]       rm_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      result_o,
  output logic [4:0]       fflags_o
);

  localparam int LZW = $clog2(SIG_W) + 1;
  localparam int EW  = ((EXP_W > 8) ? EXP_W : 8) + LZW + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NORM  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] e_q, e_d;
  logic [SIG_W-1:0]     sig_q, sig_d;
  logic [5:0]           cls_q, cls_d;
  logic [2:0]           rm_q, rm_d;
  logic                 sticky_q, sticky_d;
  logic                 tiny_q, tiny_d;
  logic [31:0]          result_q, result_d;
  logic [4:0]           fflags_q, fflags_d;

  logic                 finite;
  logic [LZW-1:0]       lz;
  logic [EW-1:0]        shamt;
  logic [23:0]          m;
  logic                 g, s, nx, inc;
  logic [24:0]          sum;
  logic [22:0]          mant;
  logic signed [EW-1:0] e_r;
  logic                 sat_max;

  function automatic logic [LZW-1:0] clz(input logic [SIG_W-1:0] v);
    clz = LZW'(SIG_W);
    for (int i = 0; i < SIG_W; i++)
      if (v[i]) clz = LZW'(SIG_W - 1 - i);
  endfunction

  assign finite = cls_q[1] | cls_q[2];
  assign lz     = clz(sig_q);
  assign shamt  = EW'(1) - e_q;

  always_comb begin
    m    = sig_q[SIG_W-1 -: 24];
    g    = sig_q[SIG_W-25];
    s    = (|sig_q[SIG_W-26:0]) | sticky_q;
    nx   = g | s;
    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = nx & sign_q;
      3'd3:    inc = nx & ~sign_q;
      3'd4:    inc = g;
      default: inc = g & (s | m[0]);
    endcase
    sum  = {1'b0, m} + 25'(inc);
    e_r  = e_q;
    mant = sum[22:0];
    // A carry out renormalizes; a subnormal carrying into bit 23 is min normal
    if (sum[24]) begin
      mant = '0;
      e_r  = e_q + EW'(1);
    end else if (e_q == '0 && sum[23]) begin
      e_r  = EW'(1);
    end
    sat_max = (rm_q == 3'd1)
            | (rm_q == 3'd2 & ~sign_q)
            | (rm_q == 3'd3 & sign_q);
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    e_d      = e_q;
    sig_d    = sig_q;
    cls_d    = cls_q;
    rm_d     = rm_q;
    sticky_d = sticky_q;
    tiny_d   = tiny_q;
    result_d = result_q;
    fflags_d = fflags_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          sign_d   = sign_i;
          e_d      = {{(EW-EXP_W){exp_i[EXP_W-1]}}, exp_i};
          sig_d    = sig_i;
          cls_d    = class_i;
          rm_d     = rm_i;
          sticky_d = 1'b0;
          tiny_d   = 1'b0;
          state_d  = S_NORM;
        end
      end
      S_NORM: begin
        if (finite) begin
          if (sig_q == '0) begin
            cls_d = 6'b000001;
          end else begin
            sig_d = sig_q << lz;
            e_d   = e_q - EW'(lz) + EW'(127);
          end
        end
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (finite && e_q < 1) begin
          tiny_d = 1'b1;
          e_d    = '0;
          if (shamt >= EW'(SIG_W)) begin
            sig_d    = '0;
            sticky_d = |sig_q;
          end else begin
            sig_d    = sig_q >> shamt;
            sticky_d = |(sig_q & ~({SIG_W{1'b1}} << shamt));
          end
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (!finite) begin
          fflags_d = '0;
          case (1'b1)
            cls_q[4], cls_q[5]: begin
              result_d    = 32'h7FC0_0000;
              fflags_d[4] = cls_q[4];
            end
            cls_q[3]: result_d = {sign_q, 8'hFF, 23'h0};
            cls_q[0]: result_d = {sign_q, 31'h0};
            default:  result_d = {sign_q, 31'h0};
          endcase
        end else if (e_r >= 255) begin
          result_d = sat_max ? {sign_q, 31'h7F7F_FFFF}
                             : {sign_q, 8'hFF, 23'h0};
          fflags_d = 5'b00101;
        end else begin
          result_d = {sign_q, e_r[7:0], mant};
          fflags_d = {3'b000, tiny_q & nx, nx};
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      e_q      <= '0;
      sig_q    <= '0;
      cls_q    <= '0;
      rm_q     <= '0;
      sticky_q <= 1'b0;
      tiny_q   <= 1'b0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      e_q      <= e_d;
      sig_q    <= sig_d;
      cls_q    <= cls_d;
      rm_q     <= rm_d;
      sticky_q <= sticky_d;
      tiny_q   <= tiny_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
    end
  end

  assign ready_o  = resetn_i & (state_q == S_IDLE);
  assign valid_o  = (state_q == S_OUT);
  assign result_o = result_q;
  assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpack_round.sv
// tb_fpack_round: directed vectors for the single-precision packer.
// Each scenario task drives its stimulus and checks results inline.
module tb_fpack_round;

  logic        clk;
  logic        resetn;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [9:0]  exp_i;
  logic [47:0] sig_i;
  logic [5:0]  class_i;
  logic [2:0]  rm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  int vectors = 0;
  int errors  = 0;

  localparam logic [5:0] C_ZERO = 6'b000001;
  localparam logic [5:0] C_NORM = 6'b000100;
  localparam logic [5:0] C_INF  = 6'b001000;
  localparam logic [5:0] C_SNAN = 6'b010000;
  localparam logic [5:0] C_QNAN = 6'b100000;

  fpack_round #(.SIG_W(48), .EXP_W(10)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .sign_i   (sign_i),
    .exp_i    (exp_i),
    .sig_i    (sig_i),
    .class_i  (class_i),
    .rm_i     (rm_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .fflags_o (fflags_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic s, input int e, input logic [47:0] sg,
                       input logic [5:0] c, input logic [2:0] rm);
    sign_i  = s;
    exp_i   = e[9:0];
    sig_i   = sg;
    class_i = c;
    rm_i    = rm;
  endtask

  // One full transaction with ready_i high; lat counts accept edge as 1.
  task automatic run_op(input logic s, input int e, input logic [47:0] sg,
                        input logic [5:0] c, input logic [2:0] rm,
                        output logic [31:0] res, output logic [4:0] fl,
                        output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    drive(s, e, sg, c, rm);
    ready_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!valid_o) begin
      lat = -1;
      res = 'x;
      fl  = 'x;
    end else begin
      res = result_o;
      fl  = fflags_o;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    drive(1'b0, 0, '0, C_ZERO, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: valid_o=%b ready_o=%b want 0 0", valid_o, ready_o);
    end
    vectors++;
    if (result_o !== 32'h0 || fflags_o !== 5'h0) begin
      errors++;
      $display("FAIL reset_out: result=%h flags=%h want 0 0", result_o, fflags_o);
    end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready_o=%b want 1", ready_o);
    end
  endtask

  task automatic test_basic;
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    run_op(1'b0, 0, 48'h8000_0000_0000, C_NORM, 3'd0, r, f, lat);
    vectors++;
    if (r !== 32'h3F80_0000 || f !== 5'h00) begin
      errors++;
      $display("FAIL basic: result=%h flags=%h want 3f800000 00", r, f);
    end
    vectors++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    run_op(1'b0, 47, 48'h0000_0000_0003, C_NORM, 3'd0, r, f, lat);
    vectors++;
    if (r !== 32'h4040_0000 || f !== 5'h00) begin
      errors++;
      $display("FAIL normalize: result=%h flags=%h want 40400000 00", r, f);
    end
  endtask

  task automatic test_rounding;
    logic        ts [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic [47:0] tg [8] = '{48'hFFFF_FF80_0000, 48'hFFFF_FF80_0000,
                            48'hFFFF_FF80_0000, 48'h8000_0000_0001,
                            48'h8000_0080_0000, 48'h8000_0080_0000,
                            48'h8000_0080_0000, 48'h8000_0180_0000};
    logic [2:0]  tm [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5, 3'd0};
    logic [31:0] tr [8] = '{32'h4000_0000, 32'h3FFF_FFFF, 32'hC000_0000,
                            32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0000,
                            32'h3F80_0000, 32'h3F80_0002};
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ts[i], 0, tg[i], C_NORM, tm[i], r, f, lat);
      vectors++;
      if (r !== tr[i] || f !== 5'h01) begin
        errors++;
        $display("FAIL round_%0d: result=%h flags=%h want %h 01", i, r, f, tr[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic        ts [4] = '{0, 0, 1, 0};
    logic [2:0]  tm [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] tr [4] = '{32'h7F80_0000, 32'h7F7F_FFFF,
                            32'hFF7F_FFFF, 32'h7F7F_FFFF};
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ts[i], 128, 48'h8000_0000_0000, C_NORM, tm[i], r, f, lat);
      vectors++;
      if (r !== tr[i] || f !== 5'h05) begin
        errors++;
        $display("FAIL overflow_%0d: result=%h flags=%h want %h 05", i, r, f, tr[i]);
      end
    end
  endtask

  task automatic test_subnormal;
    int          te [5] = '{-128, -127, -150, -127, -300};
    logic [47:0] tg [5] = '{48'h8000_0000_0000, 48'h8000_0000_0000,
                            48'hC000_0000_0000, 48'hFFFF_FF80_0000,
                            48'h8000_0000_0000};
    logic [31:0] tr [5] = '{32'h0020_0000, 32'h0040_0000, 32'h0000_0001,
                            32'h0080_0000, 32'h0000_0000};
    logic [4:0]  tf [5] = '{5'h00, 5'h00, 5'h03, 5'h03, 5'h03};
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, te[i], tg[i], C_NORM, 3'd0, r, f, lat);
      vectors++;
      if (r !== tr[i] || f !== tf[i]) begin
        errors++;
        $display("FAIL subnormal_%0d: result=%h flags=%h want %h %h",
                 i, r, f, tr[i], tf[i]);
      end
    end
  endtask

  task automatic test_specials;
    logic        ts [5] = '{0, 1, 1, 1, 0};
    logic [5:0]  tc [5] = '{C_SNAN, C_QNAN, C_INF, C_ZERO, C_NORM};
    logic [31:0] tr [5] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000,
                            32'h8000_0000, 32'h0000_0000};
    logic [4:0]  tf [5] = '{5'h10, 5'h00, 5'h00, 5'h00, 5'h00};
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ts[i], 5, (i == 4) ? 48'h0 : 48'h8000_0000_0001,
             tc[i], 3'd0, r, f, lat);
      vectors++;
      if (r !== tr[i] || f !== tf[i] || lat !== 4) begin
        errors++;
        $display("FAIL special_%0d: result=%h flags=%h lat=%0d want %h %h 4",
                 i, r, f, lat, tr[i], tf[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int   n;
    logic saw;
    @(negedge clk);
    drive(1'b0, 0, 48'h8000_0000_0000, C_NORM, 3'd0);
    ready_i = 1'b0;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    vectors++;
    if (valid_o !== 1'b1 || result_o !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL bp_first: valid=%b result=%h want 1 3f800000", valid_o, result_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 3, 48'hC000_0000_0000, C_NORM, 3'd1);
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 ||
          result_o !== 32'h3F80_0000 || fflags_o !== 5'h00) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b result=%h flags=%h want 1 0 3f800000 00",
                 i, valid_o, ready_o, result_o, fflags_o);
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 1", valid_o, ready_o);
    end
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 saw = saw | valid_o;
    end
    vectors++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored: valid_o seen=%b want 0", saw);
    end
  endtask

  task automatic test_reset_mid;
    logic        saw;
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    @(negedge clk);
    drive(1'b0, 0, 48'h8000_0000_0000, C_NORM, 3'd0);
    ready_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold: valid=%b ready=%b want 0 0", valid_o, ready_o);
    end
    @(negedge clk) resetn = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 saw = saw | valid_o;
    end
    vectors++;
    if (saw !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_drop: valid seen=%b ready=%b want 0 1", saw, ready_o);
    end
    run_op(1'b1, 1, 48'h8000_0000_0000, C_NORM, 3'd0, r, f, lat);
    vectors++;
    if (r !== 32'hC000_0000 || f !== 5'h00 || lat !== 4) begin
      errors++;
      $display("FAIL rst_mid_recover: result=%h flags=%h lat=%0d want c0000000 00 4",
               r, f, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_subnormal();
    test_specials();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
